// File: rtl/ir_pkg.sv
// Shared types for the IR execute core: opcodes, instruction fields and decode helpers.
// Optional status flags are enabled by defining IR_FLAGS_EN.
package ir_pkg;

    localparam int DATA_W  = 16;
    localparam int NUM_GPR = 32;
    localparam int REG_AW  = 5;
    localparam int OP_W    = 5;

    localparam int OPER_LSB  = 27;
    localparam int RDST_LSB  = 22;
    localparam int RSRC1_LSB = 17;
    localparam int IMM_BIT   = 16;
    localparam int RSRC2_LSB = 11;
    localparam int ISRC_LSB  = 0;

    typedef enum logic [OP_W-1:0] {
        OP_MOVSGPR = 5'd0,
        OP_MOV     = 5'd1,
        OP_ADD     = 5'd2,
        OP_SUB     = 5'd3,
        OP_MUL     = 5'd4,
        OP_OR      = 5'd5,
        OP_AND     = 5'd6,
        OP_XOR     = 5'd7,
        OP_XNOR    = 5'd8,
        OP_NAND    = 5'd9,
        OP_NOR     = 5'd10,
        OP_NOT     = 5'd11
    } opcode_e;

    // rsrc2 and isrc overlap in the word; both views are kept for readability.
    typedef struct packed {
        logic [OP_W-1:0]   oper_type;
        logic [REG_AW-1:0] rdst;
        logic [REG_AW-1:0] rsrc1;
        logic              imm_mode;
        logic [REG_AW-1:0] rsrc2;
        logic [DATA_W-1:0] isrc;
    } instr_t;

    function automatic instr_t decode(input logic [31:0] ir);
        instr_t d;
        d.oper_type = ir[OPER_LSB +: OP_W];
        d.rdst      = ir[RDST_LSB +: REG_AW];
        d.rsrc1     = ir[RSRC1_LSB +: REG_AW];
        d.imm_mode  = ir[IMM_BIT];
        d.rsrc2     = ir[RSRC2_LSB +: REG_AW];
        d.isrc      = ir[ISRC_LSB +: DATA_W];
        return d;
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return op <= OP_NOT;
    endfunction

endpackage

// File: rtl/ir_exec_core_if.sv
// Instruction/debug bus of the IR execute core; flags_o exists only with IR_FLAGS_EN.
interface ir_exec_core_if;
    import ir_pkg::*;

    logic [31:0]       instr_i;
    logic              instr_valid_i;
    logic [REG_AW-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_data_o;
    logic [DATA_W-1:0] sgpr_o;
    logic              illegal_o;
`ifdef IR_FLAGS_EN
    logic [3:0]        flags_o;
`endif

    modport master (
        output instr_i, instr_valid_i, dbg_addr_i,
`ifdef IR_FLAGS_EN
        input  flags_o,
`endif
        input  dbg_data_o, sgpr_o, illegal_o
    );

    modport slave (
        input  instr_i, instr_valid_i, dbg_addr_i,
`ifdef IR_FLAGS_EN
        output flags_o,
`endif
        output dbg_data_o, sgpr_o, illegal_o
    );

endinterface

// File: rtl/ir_alu.sv
// Combinational ALU for the IR core: result, high half of MUL and (with IR_FLAGS_EN) status flags.
module ir_alu
    import ir_pkg::*;
(
    input  opcode_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              imm_mode_i,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] mul_high_o
`ifdef IR_FLAGS_EN
    ,
    output logic [3:0]        flags_o
`endif
);

    logic [2*DATA_W-1:0] prod;

    assign prod       = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
    assign mul_high_o = prod[2*DATA_W-1:DATA_W];

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        result_o = '0;
        case (op_i)
            OP_MOV:  result_o = imm_mode_i ? b_i : a_i;
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_MUL:  result_o = prod[DATA_W-1:0];
            OP_OR:   result_o = a_i | b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_XNOR: result_o = ~(a_i ^ b_i);
            OP_NAND: result_o = ~(a_i & b_i);
            OP_NOR:  result_o = ~(a_i | b_i);
            // In immediate mode operand B already carries isrc.
            OP_NOT:  result_o = imm_mode_i ? ~b_i : ~a_i;
            default: result_o = '0;
        endcase
    end

`ifdef IR_FLAGS_EN
    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] diff_ext;
    logic            carry;
    logic            overflow;

    assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_ext = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        carry    = 1'b0;
        overflow = 1'b0;
        case (op_i)
            OP_ADD: begin
                carry    = sum_ext[DATA_W];
                overflow = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                           (sum_ext[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_SUB: begin
                carry    = diff_ext[DATA_W];
                overflow = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                           (diff_ext[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_MUL:  carry = |mul_high_o;
            default: carry = 1'b0;
        endcase
    end

    assign flags_o = {result_o[DATA_W-1], (result_o == '0), overflow, carry};
`endif

endmodule

// File: rtl/ir_exec_core.sv
// Single-issue execute/writeback core: 32x16 GPR file, SGPR for MUL high half, illegal-op pulse.
// Defining IR_FLAGS_EN adds registered {sign, zero, overflow, carry} flags on flags_o.
module ir_exec_core
    import ir_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    ir_exec_core_if.slave  core_if
);

    instr_t            ir;
    logic              legal;
    logic              exec;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mul_high;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic [DATA_W-1:0] sgpr_q, sgpr_d;
    logic              illegal_q, illegal_d;

    assign ir    = decode(core_if.instr_i);
    assign legal = is_legal(ir.oper_type);
    assign exec  = core_if.instr_valid_i && legal;
    assign op_a  = gpr_q[ir.rsrc1];
    assign op_b  = ir.imm_mode ? ir.isrc : gpr_q[ir.rsrc2];

`ifdef IR_FLAGS_EN
    logic [3:0] alu_flags;
    logic [3:0] flags_q, flags_d;
`endif

    ir_alu u_alu (
        .op_i       (opcode_e'(ir.oper_type)),
        .a_i        (op_a),
        .b_i        (op_b),
        .imm_mode_i (ir.imm_mode),
        .result_o   (alu_result),
        .mul_high_o (mul_high)
`ifdef IR_FLAGS_EN
        ,
        .flags_o    (alu_flags)
`endif
    );

    always_comb begin
        wr_data   = alu_result;
        sgpr_d    = sgpr_q;
        illegal_d = core_if.instr_valid_i && !legal;
        if (exec) begin
            case (opcode_e'(ir.oper_type))
                OP_MOVSGPR: wr_data = sgpr_q;
                OP_MUL:     sgpr_d  = mul_high;
                default:    ;
            endcase
        end
    end

`ifdef IR_FLAGS_EN
    // MOV and MOVSGPR are legal but deliberately leave the flags alone.
    always_comb begin
        flags_d = flags_q;
        if (exec && (ir.oper_type >= OP_ADD)) flags_d = alu_flags;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the GPR file is reset as flops, which rules out mapping it onto a RAM macro.
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
            sgpr_q    <= '0;
            illegal_q <= 1'b0;
`ifdef IR_FLAGS_EN
            flags_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking writes let an instruction read old values of its own rdst.
            if (exec) gpr_q[ir.rdst] <= wr_data;
            sgpr_q    <= sgpr_d;
            illegal_q <= illegal_d;
`ifdef IR_FLAGS_EN
            flags_q   <= flags_d;
`endif
        end
    end

    assign core_if.dbg_data_o = gpr_q[core_if.dbg_addr_i];
    assign core_if.sgpr_o     = sgpr_q;
    assign core_if.illegal_o  = illegal_q;
`ifdef IR_FLAGS_EN
    assign core_if.flags_o    = flags_q;
`endif

endmodule

// File: tb/tb_ir_exec_core.sv
// Self-checking bench for ir_exec_core: directed test-plan steps, then random instructions vs a reference model.
module tb_ir_exec_core;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    ir_exec_core_if bus ();

    ir_exec_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .core_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_gpr [32];
    logic [15:0] m_sgpr;
    logic        m_ill;
    logic [3:0]  m_flags;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                        input bit imm, input int src);
        logic [31:0] o, d, s1, sr;
        o  = op;
        d  = rd;
        s1 = rs1;
        sr = src;
        return {o[4:0], d[4:0], s1[4:0], imm, sr[15:0]};
    endfunction

    function automatic int s16(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_sgpr  = '0;
        m_ill   = 1'b0;
        m_flags = '0;
    endfunction

    // Applies one executed instruction to the model using plain integer arithmetic.
    function automatic void model_step(input logic [31:0] ir);
        int unsigned op, rd, rs1, rs2, isrc, a, b, r, p;
        bit imm, c, v;
        int sr;
        op   = ir[31:27];
        rd   = ir[26:22];
        rs1  = ir[21:17];
        imm  = ir[16];
        rs2  = ir[15:11];
        isrc = ir[15:0];
        a    = m_gpr[rs1];
        b    = imm ? isrc : m_gpr[rs2];
        c    = 1'b0;
        v    = 1'b0;
        m_ill = (op > 11);
        if (op > 11) return;
        case (op)
            0:  r = m_sgpr;
            1:  r = imm ? isrc : a;
            2:  begin
                    r  = a + b;
                    c  = (r > 65535);
                    sr = s16(a) + s16(b);
                    v  = (sr > 32767) || (sr < -32768);
                end
            3:  begin
                    r  = a - b;
                    c  = (a < b);
                    sr = s16(a) - s16(b);
                    v  = (sr > 32767) || (sr < -32768);
                end
            4:  begin
                    p      = a * b;
                    r      = p;
                    m_sgpr = p >> 16;
                    c      = ((p >> 16) != 0);
                end
            5:  r = a | b;
            6:  r = a & b;
            7:  r = a ^ b;
            8:  r = ~(a ^ b);
            9:  r = ~(a & b);
            10: r = ~(a | b);
            default: r = imm ? ~isrc : ~a;
        endcase
        r = r & 32'hFFFF;
        m_gpr[rd] = r[15:0];
        if (op >= 2) m_flags = {r[15], (r == 0), v, c};
    endfunction

    // Called at a negedge; leaves valid asserted so consecutive calls are back-to-back.
    task automatic exec(input logic [31:0] ir);
        bus.instr_i       = ir;
        bus.instr_valid_i = 1'b1;
        @(posedge clk);
        model_step(ir);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = $urandom;
        @(posedge clk);
        m_ill = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_gpr(input int addr, output logic [15:0] d);
        logic [31:0] a;
        a = addr;
        bus.dbg_addr_i = a[4:0];
        #1;
        d = bus.dbg_data_o;
    endtask

    task automatic check_state(input int rd);
        logic [15:0] d;
        int ra;
        rd_gpr(rd, d);
        check($sformatf("gpr[%0d]", rd), d, m_gpr[rd]);
        ra = $urandom_range(0, 31);
        rd_gpr(ra, d);
        check($sformatf("gpr[%0d]", ra), d, m_gpr[ra]);
        check("sgpr", bus.sgpr_o, m_sgpr);
        check("illegal", bus.illegal_o, m_ill);
`ifdef IR_FLAGS_EN
        check("flags", bus.flags_o, m_flags);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        logic [15:0] d;
        for (int i = 0; i < 32; i++) begin
            rd_gpr(i, d);
            check($sformatf("%s_gpr[%0d]", tag, i), d, 16'h0000);
        end
        check({tag, "_sgpr"}, bus.sgpr_o, 16'h0000);
        check({tag, "_illegal"}, bus.illegal_o, 1'b0);
`ifdef IR_FLAGS_EN
        check({tag, "_flags"}, bus.flags_o, 4'h0);
`endif
    endtask

    logic [15:0] d;
    logic [15:0] corner [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h00FF};

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n             = 1'b0;
        bus.instr_i       = '0;
        bus.instr_valid_i = 1'b0;
        bus.dbg_addr_i    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ADD immediate: GPR[2]=2, +4 -> GPR[0]=6
        exec(enc(1, 2, 0, 1, 2));
        exec(enc(2, 0, 2, 1, 4));
        check_state(0);
        rd_gpr(0, d);
        check("add_imm", d, 16'd6);

        // ADD register: GPR[4]=GPR[5]=2 -> GPR[0]=4
        exec(enc(1, 4, 0, 1, 2));
        exec(enc(1, 5, 0, 1, 2));
        exec(enc(2, 0, 4, 0, 5 << 11));
        check_state(0);
        rd_gpr(0, d);
        check("add_reg", d, 16'd4);

        // MOVI then MOV register
        exec(enc(1, 4, 0, 1, 55));
        rd_gpr(4, d);
        check("movi", d, 16'd55);
        exec(enc(1, 7, 0, 1, 2));
        exec(enc(1, 4, 7, 0, 0));
        check_state(4);
        rd_gpr(4, d);
        check("mov_reg", d, 16'd2);

        // MUL low/high split, then MOVSGPR
        exec(enc(1, 1, 0, 1, 16'h1234));
        exec(enc(1, 2, 0, 1, 16'h0100));
        exec(enc(4, 0, 1, 0, 2 << 11));
        check_state(0);
        rd_gpr(0, d);
        check("mul_low", d, 16'h3400);
        check("mul_high", bus.sgpr_o, 16'h0012);
        exec(enc(0, 3, 0, 0, 0));
        check_state(3);
        rd_gpr(3, d);
        check("movsgpr", d, 16'h0012);

        // ADD wrap 0xFFFF + 1
        exec(enc(1, 6, 0, 1, 16'hFFFF));
        exec(enc(2, 8, 6, 1, 1));
        check_state(8);
        rd_gpr(8, d);
        check("add_wrap", d, 16'h0000);
`ifdef IR_FLAGS_EN
        check("add_wrap_flags", bus.flags_o, 4'b0101);
`endif

        // Undefined opcode: no state change, one-cycle illegal pulse
        exec(enc(20, 5, 1, 1, 16'hABCD));
        check_state(5);
        check("illegal_pulse", bus.illegal_o, 1'b1);
        idle();
        check_state(5);
        check("illegal_clear", bus.illegal_o, 1'b0);

        // Same-register source/destination
        exec(enc(2, 6, 6, 0, 6 << 11));
        check_state(6);

        // Randomized mix of legal, illegal and idle cycles, with corner operands seeded
        for (int i = 0; i < 8; i++)
            exec(enc(1, $urandom_range(0, 31), 0, 1, corner[$urandom_range(0, 5)]));
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ir;
            int op;
            if ($urandom_range(0, 9) == 0) begin
                idle();
                check_state($urandom_range(0, 31));
            end else begin
                op = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 31) : $urandom_range(0, 11);
                ir = $urandom;
                ir[31:27] = op[4:0];
                if ($urandom_range(0, 4) == 0) ir[15:0] = corner[$urandom_range(0, 5)];
                exec(ir);
                check_state(ir[26:22]);
            end
        end

        // Mid-stream reset, with a valid instruction held across an edge during reset
        exec(enc(1, 9, 0, 1, 16'hBEEF));
        rd_gpr(9, d);
        check("pre_reset", d, 16'hBEEF);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("midreset");
        bus.instr_i       = enc(1, 9, 0, 1, 16'h1111);
        bus.instr_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("postreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_exec_core.md
Name: ir_exec_core

Overview:
Single-issue execute/writeback core for the team's 32-bit IR format, with a 32-entry by 16-bit GPR file and a special register SGPR that holds the high half of a multiply. The core takes one instruction per clock and decodes it. It executes register or immediate ALU/move operations and writes the result on the next rising edge. It is the datapath heart of the micro-processor top; fetch and sequencing sit outside.

Parameters:
DATA_W, 16, GPR and immediate width. Fixed by the IR format; not meant to be overridden.
NUM_GPR, 32, number of GPRs. Matches the 5-bit register fields.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_i  in  32  instruction word
instr_valid_i  in  1  instruction is executed on this edge when high
dbg_addr_i  in  5  GPR debug read address
dbg_data_o  out  16  GPR[dbg_addr_i], combinational from registered state
sgpr_o  out  16  current SGPR value
illegal_o  out  1  registered; 1 for one cycle after a valid instruction with an undefined opcode

Behaviour:
- IR fields:
  - oper_type = IR[31:27]
  - rdst = IR[26:22]
  - rsrc1 = IR[21:17]
  - imm_mode = IR[16]
  - rsrc2 = IR[15:11]
  - isrc = IR[15:0]
- Operand B = imm_mode ? isrc : GPR[rsrc2]. Operand A = GPR[rsrc1].
- Opcodes:
  - 0 MOVSGPR: rdst <= SGPR
  - 1 MOV: rdst <= imm_mode ? isrc : GPR[rsrc1]
  - 2 ADD
  - 3 SUB (A-B)
  - 4 MUL: 32-bit product; rdst <= low 16 bits, SGPR <= high 16 bits
  - 5 OR
  - 6 AND
  - 7 XOR
  - 8 XNOR
  - 9 NAND
  - 10 NOR
  - 11 NOT (~A, or ~isrc when imm_mode)
- ADD/SUB wrap modulo 2^16; results are truncated to 16 bits.
- Latency: write occurs on the rising edge at which instr_valid_i=1, and is visible on dbg_data_o immediately after that edge. Throughput is one instruction per cycle.
- Back-to-back dependency: an instruction reads register state as of the edge it executes on. The previous instruction's result is already written, so no hazard exists.
- rdst equal to rsrc1/rsrc2 is legal; the read uses the old value and the write stores the new one.
- All 32 GPRs are ordinary storage; GPR[0] is not hardwired.
- Opcodes 12..31 change no state and set illegal_o=1 for one cycle.
- instr_valid_i=0: no state change; illegal_o=0.
- Reset (asynchronous assert, synchronous deassert handled externally): all GPRs=0, SGPR=0, illegal_o=0, flags=0. Reset mid-stream discards any instruction presented at that edge.

Optional Feature:
Macro IR_FLAGS_EN.
- When defined, adds output flags_o[3:0] = {sign, zero, overflow, carry}, registered. It updates on every valid ALU op (2..11):
  - sign = result[15]
  - zero = (result==0)
  - carry = bit 16 of an unsigned ADD, or the borrow of SUB; 0 otherwise
  - overflow = signed overflow of ADD/SUB; 0 otherwise
- For MUL, carry = (high half != 0).
- MOV/MOVSGPR/illegal/idle leave flags unchanged. Flags reset to 0.
- When not defined, the port and logic are absent.

Decomposition:
- Package ir_pkg:
  - opcode enum (values 0..11)
  - field bit-position localparams
  - DATA_W
  - instruction struct typedef (oper_type, rdst, rsrc1, imm_mode, rsrc2/isrc)
- One sub-module ir_alu: combinational; inputs opcode, A, B, imm_mode; outputs 16-bit result, 16-bit mul_high, and flags.
- The register file and SGPR stay in ir_exec_core.

Test Plan:
- Reset, then ADD imm (oper=2, imm_mode=1, rsrc1=2, rdst=0, isrc=4) with GPR[2]=2 (preloaded via MOVI) -> GPR[0]=6.
- ADD reg (imm_mode=0, rsrc1=4, rsrc2=5, rdst=0) with GPR[4]=GPR[5]=2 -> GPR[0]=4.
- MOVI rdst=4, isrc=55 -> GPR[4]=55; then MOV rdst=4, rsrc1=7 with GPR[7]=2 -> GPR[4]=2.
- MUL with GPR[1]=0x1234, GPR[2]=0x0100 -> rdst=0x3400, SGPR=0x0012. Then MOVSGPR rdst=3 -> GPR[3]=0x0012.
- ADD 0xFFFF+1 -> result 0. With IR_FLAGS_EN: zero=1, carry=1.
- Opcode 20 with valid=1 -> no GPR change, illegal_o pulses 1 cycle. Assert rst_n=0 mid-sequence -> all GPRs and SGPR read 0 immediately.
